// File: rtl/cmm_matrix_loader.sv
// Assembles a streamed R matrix, SH matrix and scalar d into one parallel frame
// for the complex matrix multiplier, with tlast framing checks and error counting.
module cmm_matrix_loader #(
  parameter int WIDTH = 32,
  parameter int SIZE  = 4
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [WIDTH-1:0]              s_axis_tdata,
  input  logic                          s_axis_tvalid,
  input  logic                          s_axis_tlast,
  output logic                          s_axis_tready,
  input  logic [WIDTH-1:0]              s_axis_d_tdata,
  output logic [WIDTH*SIZE*SIZE-1:0]    m_axis_r_tdata,
  output logic [WIDTH*SIZE*SIZE-1:0]    m_axis_sh_tdata,
  output logic [WIDTH-1:0]              m_axis_d_tdata,
  output logic                          m_axis_tvalid,
  input  logic                          m_axis_tready,
  output logic                          frame_err,
  output logic [7:0]                    err_count
);

  localparam int N  = SIZE * SIZE;
  localparam int CW = (N > 1) ? $clog2(N) : 1;
  localparam logic [CW-1:0] LAST_IDX = CW'(N - 1);

  typedef enum logic [1:0] {LOAD_R, LOAD_SH, HOLD, DRAIN} state_t;

  state_t        state, state_nxt;
  logic [CW-1:0] cnt, cnt_nxt;
  logic          accept;
  logic          err_evt;
  logic          wr_r;
  logic          wr_sh;
  logic          cap_d;

  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  assign s_axis_tready = (state != HOLD);
  assign m_axis_tvalid = (state == HOLD);
  assign accept        = s_axis_tvalid && s_axis_tready;

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= LOAD_R;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    err_evt   = 1'b0;
    wr_r      = 1'b0;
    wr_sh     = 1'b0;
    cap_d     = 1'b0;
    case (state)
      LOAD_R: begin
        if (accept) begin
          wr_r  = 1'b1;
          cap_d = (cnt == '0);
          // Any tlast inside the R half is early: the frame ends in SH.
          if (s_axis_tlast) begin
            err_evt = 1'b1;
            cnt_nxt = '0;
          end else if (cnt == LAST_IDX) begin
            state_nxt = LOAD_SH;
            cnt_nxt   = '0;
          end else begin
            cnt_nxt = cnt + 1'b1;
          end
        end
      end
      LOAD_SH: begin
        if (accept) begin
          wr_sh = 1'b1;
          if (cnt == LAST_IDX) begin
            cnt_nxt = '0;
            if (s_axis_tlast) begin
              state_nxt = HOLD;
            end else begin
              err_evt   = 1'b1;
              state_nxt = DRAIN;
            end
          end else if (s_axis_tlast) begin
            err_evt   = 1'b1;
            state_nxt = LOAD_R;
            cnt_nxt   = '0;
          end else begin
            cnt_nxt = cnt + 1'b1;
          end
        end
      end
      HOLD: begin
        if (m_axis_tready) begin
          state_nxt = LOAD_R;
          cnt_nxt   = '0;
        end
      end
      DRAIN: begin
        if (accept && s_axis_tlast) begin
          state_nxt = LOAD_R;
          cnt_nxt   = '0;
        end
      end
      default: begin
        state_nxt = LOAD_R;
        cnt_nxt   = '0;
      end
    endcase
  end

  // Frame buffers double as the output ports; they hold until overwritten.
  always_ff @(posedge clk) begin
    if (reset) begin
      m_axis_r_tdata  <= '0;
      m_axis_sh_tdata <= '0;
      m_axis_d_tdata  <= '0;
    end else begin
      if (wr_r)
        m_axis_r_tdata[WIDTH*int'(cnt) +: WIDTH] <= s_axis_tdata;
      if (wr_sh)
        m_axis_sh_tdata[WIDTH*int'(cnt) +: WIDTH] <= s_axis_tdata;
      if (cap_d)
        m_axis_d_tdata <= s_axis_d_tdata;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      frame_err <= 1'b0;
      err_count <= 8'd0;
    end else begin
      frame_err <= err_evt;
      if (err_evt)
        err_count <= sat_inc(err_count);
    end
  end

endmodule

// File: tb/tb_cmm_matrix_loader.sv
// Directed bench for cmm_matrix_loader: frame-position model of the expected
// outputs, checked every cycle, plus literal spot checks on key values.
module tb_cmm_matrix_loader;

  localparam int W  = 32;
  localparam int S  = 4;
  localparam int N  = S * S;
  localparam int MW = W * N;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic [W-1:0]  s_axis_tdata = '0;
  logic          s_axis_tvalid = 1'b0;
  logic          s_axis_tlast = 1'b0;
  logic          s_axis_tready;
  logic [W-1:0]  s_axis_d_tdata = '0;
  logic [MW-1:0] m_axis_r_tdata;
  logic [MW-1:0] m_axis_sh_tdata;
  logic [W-1:0]  m_axis_d_tdata;
  logic          m_axis_tvalid;
  logic          m_axis_tready = 1'b0;
  logic          frame_err;
  logic [7:0]    err_count;

  cmm_matrix_loader #(.WIDTH(W), .SIZE(S)) dut (
    .clk             (clk),
    .reset           (reset),
    .s_axis_tdata    (s_axis_tdata),
    .s_axis_tvalid   (s_axis_tvalid),
    .s_axis_tlast    (s_axis_tlast),
    .s_axis_tready   (s_axis_tready),
    .s_axis_d_tdata  (s_axis_d_tdata),
    .m_axis_r_tdata  (m_axis_r_tdata),
    .m_axis_sh_tdata (m_axis_sh_tdata),
    .m_axis_d_tdata  (m_axis_d_tdata),
    .m_axis_tvalid   (m_axis_tvalid),
    .m_axis_tready   (m_axis_tready),
    .frame_err       (frame_err),
    .err_count       (err_count)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;
  int cyc    = 0;
  bit run    = 1'b0;

  task automatic check(input string name, input logic [MW-1:0] act, input logic [MW-1:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Model: position within the 2*N-beat frame, plus holding/draining flags.
  int            m_pos   = 0;
  bit            m_hold  = 1'b0;
  bit            m_drain = 1'b0;
  logic [MW-1:0] m_r     = '0;
  logic [MW-1:0] m_sh    = '0;
  logic [W-1:0]  m_d     = '0;
  int            m_errs  = 0;
  bit            m_ferr  = 1'b0;

  always @(posedge clk) begin
    cyc++;
    m_ferr = 1'b0;
    if (reset) begin
      m_pos = 0; m_hold = 0; m_drain = 0;
      m_r = '0; m_sh = '0; m_d = '0; m_errs = 0;
    end else if (m_hold) begin
      if (m_axis_tready) m_hold = 0;
    end else if (s_axis_tvalid) begin
      if (m_drain) begin
        if (s_axis_tlast) m_drain = 0;
      end else begin
        if (m_pos < N) m_r[W*m_pos +: W] = s_axis_tdata;
        else           m_sh[W*(m_pos-N) +: W] = s_axis_tdata;
        if (m_pos == 0) m_d = s_axis_d_tdata;
        if (m_pos == 2*N-1) begin
          if (s_axis_tlast) m_hold = 1;
          else begin
            m_ferr = 1; m_drain = 1;
            m_errs = (m_errs < 255) ? m_errs + 1 : 255;
          end
          m_pos = 0;
        end else if (s_axis_tlast) begin
          m_ferr = 1; m_pos = 0;
          m_errs = (m_errs < 255) ? m_errs + 1 : 255;
        end else begin
          m_pos++;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (run) begin
      check("tready", MW'(s_axis_tready), MW'(!m_hold));
      check("m_tvalid", MW'(m_axis_tvalid), MW'(m_hold));
      check("frame_err", MW'(frame_err), MW'(m_ferr));
      check("err_count", MW'(err_count), MW'(m_errs));
      check("r_tdata", m_axis_r_tdata, m_r);
      check("sh_tdata", m_axis_sh_tdata, m_sh);
      check("d_tdata", MW'(m_axis_d_tdata), MW'(m_d));
    end
  end

  function automatic logic [W-1:0] elem(input int b, input int off);
    int k;
    k = b % N;
    return W'(k / S + k % S + off);
  endfunction

  // Drives one beat at the falling edge and waits until it is accepted.
  task automatic beat(input logic [W-1:0] data, input bit last, input bit gap);
    bit rdy;
    if (gap) begin
      s_axis_tvalid = 1'b0;
      @(negedge clk);
    end
    s_axis_tdata  = data;
    s_axis_tlast  = last;
    s_axis_tvalid = 1'b1;
    for (int t = 0; t < 100; t++) begin
      rdy = s_axis_tready;
      @(negedge clk);
      if (rdy) begin
        s_axis_tvalid = 1'b0;
        s_axis_tlast  = 1'b0;
        return;
      end
    end
    n_chk++;
    n_fail++;
    $display("FAIL beat_timeout: got no tready expected tready within 100 cycles");
    s_axis_tvalid = 1'b0;
  endtask

  task automatic send_frame(input int nbeats, input int last_at, input int off,
                            input logic [W-1:0] d, input bit gap);
    s_axis_d_tdata = d;
    for (int b = 0; b < nbeats; b++)
      beat(elem(b, off), (b == last_at), gap);
  endtask

  task automatic release_hold();
    m_axis_tready = 1'b1;
    @(negedge clk);
    m_axis_tready = 1'b0;
  endtask

  int c0;

  initial begin
    reset = 1'b1;
    @(negedge clk);
    run = 1'b1;
    @(negedge clk);
    check("rst_tvalid", MW'(m_axis_tvalid), MW'(0));
    check("rst_r", m_axis_r_tdata, '0);
    check("rst_errcnt", MW'(err_count), MW'(0));
    reset = 1'b0;
    @(negedge clk);
    check("rst_tready", MW'(s_axis_tready), MW'(1));

    // Basic frame, i+j pattern, d=1
    c0 = cyc;
    send_frame(2*N, 2*N-1, 0, 1, 0);
    check("lat_cycles", MW'(cyc - c0), MW'(32));
    check("lit_tvalid", MW'(m_axis_tvalid), MW'(1));
    check("lit_r5", MW'(m_axis_r_tdata[W*5 +: W]), MW'(2));
    check("lit_sh15", MW'(m_axis_sh_tdata[W*15 +: W]), MW'(6));
    check("lit_d", MW'(m_axis_d_tdata), MW'(1));

    // Backpressure in HOLD with a beat already offered
    s_axis_d_tdata = 7;
    s_axis_tdata   = elem(0, 100);
    s_axis_tvalid  = 1'b1;
    repeat (10) @(negedge clk);
    check("hold_tready", MW'(s_axis_tready), MW'(0));
    check("hold_r5", MW'(m_axis_r_tdata[W*5 +: W]), MW'(2));
    release_hold();
    check("hold_release", MW'(s_axis_tready), MW'(1));
    send_frame(2*N, 2*N-1, 100, 7, 0);
    check("bp_r0", MW'(m_axis_r_tdata[W*0 +: W]), MW'(100));
    check("bp_d", MW'(m_axis_d_tdata), MW'(7));
    @(negedge clk);
    release_hold();

    // Early tlast on beat 10, then a good frame
    send_frame(11, 10, 50, 3, 0);
    check("early_ferr", MW'(frame_err), MW'(1));
    check("early_cnt", MW'(err_count), MW'(1));
    send_frame(2*N, 2*N-1, 20, 4, 0);
    check("early_next_sh0", MW'(m_axis_sh_tdata[W*0 +: W]), MW'(20));
    release_hold();

    // Missing tlast on beat 31, tlast on beat 35
    send_frame(36, 35, 60, 5, 0);
    check("miss_cnt", MW'(err_count), MW'(2));
    check("miss_tvalid", MW'(m_axis_tvalid), MW'(0));
    send_frame(2*N, 2*N-1, 30, 6, 0);
    check("miss_next_r15", MW'(m_axis_r_tdata[W*15 +: W]), MW'(36));
    release_hold();

    // tvalid toggled every other cycle
    c0 = cyc;
    send_frame(2*N, 2*N-1, 0, 1, 1);
    check("gap_cycles", MW'(cyc - c0), MW'(64));
    check("gap_r5", MW'(m_axis_r_tdata[W*5 +: W]), MW'(2));
    check("gap_sh15", MW'(m_axis_sh_tdata[W*15 +: W]), MW'(6));
    release_hold();

    // Reset at beat 20
    send_frame(20, -1, 10, 9, 0);
    reset = 1'b1;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    check("mid_rst_r", m_axis_r_tdata, '0);
    check("mid_rst_sh", m_axis_sh_tdata, '0);
    check("mid_rst_d", MW'(m_axis_d_tdata), MW'(0));
    check("mid_rst_cnt", MW'(err_count), MW'(0));
    @(negedge clk);
    send_frame(2*N, 2*N-1, 40, 8, 0);
    check("fresh_r0", MW'(m_axis_r_tdata[W*0 +: W]), MW'(40));
    check("fresh_d", MW'(m_axis_d_tdata), MW'(8));
    release_hold();

    // 300 forced errors saturate the counter
    for (int e = 0; e < 300; e++)
      send_frame(1, 0, 0, 2, 0);
    check("sat_cnt", MW'(err_count), MW'(255));
    @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
